// File: rtl/imem_pkg.sv
// imem_pkg
//   Constants and types shared by the program loader and the
//   instruction memory it fills.
//   - loader_state_t : loader FSM states
//   - IMEM_DEPTH     : instruction words in memory (fetch side must match)
//   - IMEM_ADDR_W    : instruction-memory address width
//   - INSTR_W        : instruction width
//   - NOP_INSTR      : filler written into every word past the program
//   - MAX_PROG_LEN   : largest program length a load may request
//   - PROG_LEN_W     : width of the prog_len request field
package imem_pkg;

  localparam int IMEM_DEPTH   = 64;
  localparam int IMEM_ADDR_W  = 6;
  localparam int INSTR_W      = 32;
  localparam int MAX_PROG_LEN = 64;
  localparam int PROG_LEN_W   = 7;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0007_8000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_FILL  = 3'd3,
    ST_DONE  = 3'd4
  } loader_state_t;

  // A requested length is usable only when it is in 1..MAX_PROG_LEN.
  function automatic logic prog_len_ok(input logic [PROG_LEN_W-1:0] len);
    return (len != '0) && (len <= PROG_LEN_W'(MAX_PROG_LEN));
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer
//   Assembles instruction words from a byte stream, most-significant
//   byte first.  Only the three earlier bytes of a word are stored; the
//   fourth byte is taken straight from in_data so the complete word is
//   available in the same cycle the last byte is accepted.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : drop any partial word and restart at byte 0
//   shift_en    : a byte is accepted this cycle
//   in_data     : the byte being accepted
//   word_next   : word formed by the stored bytes plus in_data
//   word_valid  : shift_en on the 4th byte; word_next is complete
module imem_word_packer
  import imem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               shift_en,
  input  logic [7:0]         in_data,
  output logic [INSTR_W-1:0] word_next,
  output logic               word_valid
);

  localparam int LANES  = INSTR_W / 8;
  localparam int HIST_W = 8 * (LANES - 1);

  // hist_reg[HIST_W-1 -: 8] is the oldest (most significant) byte.
  logic [HIST_W-1:0] hist_reg;
  logic [1:0]        byte_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_reg     <= '0;
      byte_cnt_reg <= 2'd0;
    end else if (clear) begin
      hist_reg     <= '0;
      byte_cnt_reg <= 2'd0;
    end else if (shift_en) begin
      hist_reg     <= {hist_reg[HIST_W-9:0], in_data};
      // Wraps to 0 after the 4th byte, ready for the next word.
      byte_cnt_reg <= byte_cnt_reg + 2'd1;
    end
  end

  // Lane 0 of the outgoing word is the byte arriving now; higher lanes
  // come from the history register.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      if (gi == 0) begin : g_live
        assign word_next[7:0] = in_data;
      end else begin : g_hist
        assign word_next[8*gi +: 8] = hist_reg[8*(gi-1) +: 8];
      end
    end
  endgenerate

  assign word_valid = shift_en && (byte_cnt_reg == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Fills the instruction memory from a byte-serial stream, then pads the
//   remaining words with NOP so a wrapping PC only runs defined code.
//   The processor is held in reset (cpu_hold) for the whole load.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start, prog_len   : load request and program length in words (1..64)
//   in_valid, in_data : byte stream, MSB of each word first
//   in_ready          : loader accepts a byte this cycle (RECV only)
//   wr_en, wr_addr,
//   wr_data           : instruction-memory write port
//   cpu_hold          : processor reset while loading
//   busy              : loader not idle
//   done              : one-cycle completion pulse
//   err               : sticky bad-length / start-while-busy flag
// All outputs are registered.
module imem_loader #(
  parameter int IMEM_DEPTH = imem_pkg::IMEM_DEPTH,
  parameter int INSTR_W    = imem_pkg::INSTR_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [imem_pkg::PROG_LEN_W-1:0]  prog_len,
  input  logic                             in_valid,
  input  logic [7:0]                       in_data,
  output logic                             in_ready,
  output logic                             wr_en,
  output logic [imem_pkg::IMEM_ADDR_W-1:0] wr_addr,
  output logic [INSTR_W-1:0]               wr_data,
  output logic                             cpu_hold,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  import imem_pkg::*;

  localparam logic [IMEM_ADDR_W-1:0] LAST_ADDR = IMEM_ADDR_W'(IMEM_DEPTH - 1);
  localparam logic [PROG_LEN_W-1:0]  FULL_LEN  = PROG_LEN_W'(IMEM_DEPTH);

  loader_state_t          state_reg;
  logic [PROG_LEN_W-1:0]  len_reg;
  logic [IMEM_ADDR_W-1:0] word_cnt_reg;

  logic                   in_ready_reg;
  logic                   wr_en_reg;
  logic [IMEM_ADDR_W-1:0] wr_addr_reg;
  logic [INSTR_W-1:0]     wr_data_reg;
  logic                   cpu_hold_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic                   err_reg;

  logic               start_ok;
  logic               load_begin;
  logic               shift_en;
  logic [INSTR_W-1:0] word_next;
  logic               word_valid;
  logic               last_word;

  assign start_ok   = prog_len_ok(prog_len);
  assign load_begin = (state_reg == ST_IDLE) && start && start_ok;
  // in_ready_reg is high exactly in RECV, so it doubles as the
  // handshake qualifier.
  assign shift_en   = in_valid && in_ready_reg;
  assign last_word  = ({1'b0, word_cnt_reg} == (len_reg - PROG_LEN_W'(1)));

  imem_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (load_begin),
    .shift_en   (shift_en),
    .in_data    (in_data),
    .word_next  (word_next),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      len_reg      <= '0;
      word_cnt_reg <= '0;
      in_ready_reg <= 1'b0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      cpu_hold_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      // A start that arrives mid-load is flagged but otherwise ignored.
      if (start && (state_reg != ST_IDLE)) begin
        err_reg <= 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (start_ok) begin
              len_reg      <= prog_len;
              word_cnt_reg <= '0;
              err_reg      <= 1'b0;
              in_ready_reg <= 1'b1;
              cpu_hold_reg <= 1'b1;
              busy_reg     <= 1'b1;
              state_reg    <= ST_RECV;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end

        ST_RECV: begin
          // The 4th byte is written in the very next cycle.
          if (word_valid) begin
            in_ready_reg <= 1'b0;
            wr_en_reg    <= 1'b1;
            wr_addr_reg  <= word_cnt_reg;
            wr_data_reg  <= word_next;
            state_reg    <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          if (last_word) begin
            if (len_reg == FULL_LEN) begin
              // Program occupies all of memory: nothing to pad.
              wr_en_reg <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              // First pad write follows immediately at address len.
              wr_en_reg   <= 1'b1;
              wr_addr_reg <= len_reg[IMEM_ADDR_W-1:0];
              wr_data_reg <= NOP_INSTR;
              state_reg   <= ST_FILL;
            end
          end else begin
            wr_en_reg    <= 1'b0;
            word_cnt_reg <= word_cnt_reg + IMEM_ADDR_W'(1);
            in_ready_reg <= 1'b1;
            state_reg    <= ST_RECV;
          end
        end

        ST_FILL: begin
          if (wr_addr_reg == LAST_ADDR) begin
            wr_en_reg <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            wr_addr_reg <= wr_addr_reg + IMEM_ADDR_W'(1);
          end
        end

        ST_DONE: begin
          // Releasing cpu_hold here lets the processor leave reset in the
          // same cycle the loader returns to IDLE.
          done_reg     <= 1'b0;
          cpu_hold_reg <= 1'b0;
          busy_reg     <= 1'b0;
          state_reg    <= ST_IDLE;
        end

        default: begin
          in_ready_reg <= 1'b0;
          wr_en_reg    <= 1'b0;
          cpu_hold_reg <= 1'b0;
          busy_reg     <= 1'b0;
          done_reg     <= 1'b0;
          state_reg    <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready = in_ready_reg;
  assign wr_en    = wr_en_reg;
  assign wr_addr  = wr_addr_reg;
  assign wr_data  = wr_data_reg;
  assign cpu_hold = cpu_hold_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Directed bench for imem_loader.  Each load pushes the full expected
//   write sequence (program words, then NOP padding) into a queue; an
//   independent monitor pops and compares on every wr_en cycle.
module tb_imem_loader;

  import imem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  prog_len = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  imem_loader #(.IMEM_DEPTH(64), .INSTR_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .prog_len (prog_len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] prog_words [64];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // Scoreboard monitor: every write must match the head of the queue and
  // must not coincide with in_ready.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_wr: got addr %0d data %08h, no write required", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        $display("wr addr %0d data %08h (expect addr %0d data %08h)", wr_addr, wr_data, e.addr, e.data);
        check("wr", {26'b0, wr_addr, wr_data}, {26'b0, e.addr, e.data});
        check("in_ready_during_wr", in_ready, 1'b0);
      end
    end
  end

  task automatic push_prog(input int len);
    wr_t e;
    for (int i = 0; i < 64; i++) begin
      e.addr = 6'(i);
      e.data = (i < len) ? prog_words[i] : NOP_INSTR;
      exp_q.push_back(e);
    end
  endtask

  task automatic start_pulse(input logic [6:0] len);
    start = 1'b1;
    prog_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data = b;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL byte_timeout: in_ready stayed 0 for %0d cycles, required 1", t);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[8*i +: 8]);
      repeat (gap) @(negedge clk);
    end
  endtask

  // exp_lat < 0 skips the latency comparison (stalled loads).
  task automatic wait_done(input int c0, input int exp_lat);
    int t = 0;
    while (!done && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", done, 1'b1);
    if (exp_lat >= 0) check("done_latency", 64'(cyc - c0), 64'(exp_lat));
    check("hold_in_done", cpu_hold, 1'b1);
    @(negedge clk);
    check("idle_after_done", {cpu_hold, busy, done}, 3'b000);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $finish;
  end

  initial begin
    int c0;

    // Reset state
    repeat (3) @(negedge clk);
    check("outputs_in_reset", {in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, err}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {in_ready, busy}, 2'b00);

    // prog_len=1: one word then 63 NOPs
    prog_words[0] = 32'h8008_0001;
    push_prog(1);
    c0 = cyc;
    start_pulse(7'd1);
    check("hold_after_start", {cpu_hold, busy, in_ready}, 3'b111);
    send_word(32'h8008_0001, 0);
    wait_done(c0, 69);

    // prog_len=64 with in_valid toggling: no padding writes
    for (int i = 0; i < 64; i++)
      prog_words[i] = {8'(i), 8'hC3, 8'(i * 7), 8'(~i)};
    push_prog(64);
    c0 = cyc;
    start_pulse(7'd64);
    for (int i = 0; i < 64; i++) send_word(prog_words[i], 1);
    wait_done(c0, -1);

    // prog_len=0 rejected
    start_pulse(7'd0);
    check("len0_err_busy_hold", {err, busy, cpu_hold}, 3'b100);
    repeat (3) @(negedge clk);

    // Valid start clears err; prog_len=2
    prog_words[0] = 32'h1234_5678;
    prog_words[1] = 32'hDEAD_BEEF;
    push_prog(2);
    c0 = cyc;
    start_pulse(7'd2);
    check("err_cleared", {err, busy}, 2'b01);
    send_word(32'h1234_5678, 0);
    send_word(32'hDEAD_BEEF, 0);
    wait_done(c0, 73);

    // prog_len=65 rejected
    start_pulse(7'd65);
    check("len65_err_busy_hold", {err, busy, cpu_hold}, 3'b100);
    repeat (3) @(negedge clk);

    // start pulsed during RECV of word 1 is ignored for loading
    prog_words[0] = 32'h0000_0013;
    prog_words[1] = 32'h00A0_0093;
    prog_words[2] = 32'hFFF0_8113;
    push_prog(3);
    c0 = cyc;
    start_pulse(7'd3);
    check("err_cleared_again", err, 1'b0);
    send_word(32'h0000_0013, 0);
    send_byte(8'h00);
    start_pulse(7'd5);
    check("busy_start_err", {err, busy}, 2'b11);
    send_byte(8'hA0);
    send_byte(8'h00);
    send_byte(8'h93);
    send_word(32'hFFF0_8113, 0);
    wait_done(c0, -1);
    check("err_sticky", err, 1'b1);

    // Asynchronous reset after 2 bytes of word 0: no write
    start_pulse(7'd1);
    send_byte(8'h12);
    send_byte(8'h34);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", {in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, err}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_abort", {in_ready, busy}, 2'b00);

    // Restart: the new word must not mix with the discarded bytes
    prog_words[0] = 32'h0007_8000;
    push_prog(1);
    c0 = cyc;
    start_pulse(7'd1);
    send_word(32'h0007_8000, 0);
    wait_done(c0, 69);

    repeat (4) @(negedge clk);
    check("final_sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the 64-word instruction memory from a byte-serial stream, replacing the hardwired program image. It is the write side of the instruction-memory port that the fetch stage reads. It holds the processor (PC, register file, data memory) in reset while loading, then pads unused words with NOP so the wrapping PC only ever executes defined code.

## Interface
Parameters:
- IMEM_DEPTH, 64, instruction words; must equal the fetch-side memory depth.
- INSTR_W, 32, instruction width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a load; sampled only in IDLE.
- prog_len  in  7  number of words to load; valid range 1..64; sampled with start.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data; most-significant byte of each word first.
- in_ready  out  1  loader accepts in_data this cycle.
- wr_en  out  1  instruction-memory write strobe.
- wr_addr  out  6  instruction-memory write address.
- wr_data  out  32  instruction-memory write data.
- cpu_hold  out  1  drives processor reset while a load is in progress.
- busy  out  1  loader not in IDLE.
- done  out  1  one-cycle pulse on completion.
- err  out  1  sticky error flag.

## Operation
- States: IDLE, RECV, WRITE, FILL, DONE.
- IDLE: in_ready=0, wr_en=0.
  - start with 1<=prog_len<=64: latch len, word_cnt=0, byte_cnt=0, clear err, go to RECV.
  - start with prog_len==0 or >64: set err, stay IDLE, perform no writes.
- RECV: in_ready=1.
  - On in_valid&in_ready: shift word <= {word[23:0], in_data}, byte_cnt++.
  - The 4th accepted byte moves to WRITE.
  - While in_valid is low, stay in RECV; no timeout.
- WRITE: one cycle; in_ready=0, wr_en=1, wr_addr=word_cnt, wr_data=assembled word.
  - If word_cnt==len-1: go to FILL, or to DONE when len==64.
  - Otherwise word_cnt++ and return to RECV.
- FILL: one write per cycle, wr_data=NOP (32'h0007_8000), at addresses len..63. After writing address 63, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- cpu_hold=1 in RECV, WRITE, FILL and DONE; it deasserts on the IDLE entry cycle, so the processor restarts at PC 0 with the new image.
- A start pulse while busy is ignored for loading, sets err, and the load in progress continues unaffected.
- err clears only on the next valid start (or rst).
- Address arithmetic is 6-bit; no wrap beyond 63 can occur because len<=64.

## Timing
- All outputs are registered. On reset every output is 0, the state is IDLE, and the counters and word register are 0.
- rst asserted mid-load aborts immediately: the partial word is discarded, words already written stay in memory, and cpu_hold drops.
- Byte handshake: a transfer occurs on a posedge with in_valid&in_ready both high. in_ready depends only on state, never on in_valid.
- Per-word cost is at least 5 cycles (4 bytes + 1 write). FILL costs 64-len cycles.
- With no stall, a full load of len words takes 5·len + (64-len) + 1 (DONE) cycles from the first RECV cycle.
- wr_en is never high in IDLE or RECV. There is at most one write per cycle.

## Structure
- Shared package imem_pkg:
  - loader_state_t enum.
  - IMEM_DEPTH, IMEM_ADDR_W=6, INSTR_W=32.
  - NOP_INSTR=32'h0007_8000.
  - MAX_PROG_LEN=64.
- The instruction-memory model gains a write port (wr_en, wr_addr, wr_data) keyed to the same package constants.
- One natural sub-module, imem_word_packer: a byte shift register plus 2-bit byte counter with a word_valid output. The FSM and address counters stay in imem_loader.

## Test plan
- Reset with rst=1 mid-operation: all outputs 0 in the same cycle (asynchronous); after release, state is IDLE and in_ready=0.
- start, prog_len=1, bytes 80 08 00 01 → one write addr 0 data 32'h8008_0001, then 63 writes of 32'h0007_8000 at addr 1..63, done pulse; cpu_hold high from the cycle after start through DONE.
- prog_len=64 with in_valid toggling every other cycle → exactly 64 writes (addr 0..63) in order, no FILL writes, no bytes lost or duplicated, in_ready low in every WRITE cycle.
- prog_len=0, then prog_len=65 → err=1, no wr_en, busy=0. A following start with prog_len=2 clears err and loads normally.
- start pulsed during RECV of word 1 → err=1, the load still completes with correct data and done asserts.
- rst asserted after 2 bytes of word 0 → no write occurs. A restart with prog_len=1 and bytes 00 07 80 00 writes addr 0 with 32'h0007_8000, not a mix of old and new bytes.
